// File: rtl/pipe_hazard_ctrl_pkg.sv
// Shared pipeline definitions for the hazard controller: FSM state encoding,
// default register-index width and the architectural zero register.
package pipe_hazard_ctrl_pkg;

  localparam int unsigned RegIdxWidth = 4;
  localparam int unsigned RegZero     = 0;

  typedef enum logic [1:0] {
    StRun,
    StFreeze,
    StErr
  } hz_state_e;

endpackage

// File: rtl/pipe_hazard_ctrl_if.sv
// Front-end control bus between the IF/DEC/EX/MEM stages (master) and the
// hazard controller (slave).
interface pipe_hazard_ctrl_if #(
  parameter int unsigned REG_INDEX_BIT_WIDTH = pipe_hazard_ctrl_pkg::RegIdxWidth
);

  logic [REG_INDEX_BIT_WIDTH-1:0] rs1;
  logic [REG_INDEX_BIT_WIDTH-1:0] rs2;
  logic                           use_rs1;
  logic                           use_rs2;
  logic [REG_INDEX_BIT_WIDTH-1:0] DEC_rd;
  logic                           DEC_wrReg;
  logic                           DEC_ME_mux_sel;
  logic                           DEC_prediction;
  logic                           ex_br_valid;
  logic                           ex_br_taken;
  logic                           mem_req;
  logic                           mem_ready;

  logic                           pc_wrt_en;
  logic                           IF_wrt_en;
  logic                           DEC_wrt_en;
  logic                           IF_flush;
  logic                           DEC_flush;
  logic                           pc_redirect;
  logic                           mem_err;

  modport master (
    output rs1, rs2, use_rs1, use_rs2, DEC_rd, DEC_wrReg, DEC_ME_mux_sel,
           DEC_prediction, ex_br_valid, ex_br_taken, mem_req, mem_ready,
    input  pc_wrt_en, IF_wrt_en, DEC_wrt_en, IF_flush, DEC_flush, pc_redirect, mem_err
  );

  modport slave (
    input  rs1, rs2, use_rs1, use_rs2, DEC_rd, DEC_wrReg, DEC_ME_mux_sel,
           DEC_prediction, ex_br_valid, ex_br_taken, mem_req, mem_ready,
    output pc_wrt_en, IF_wrt_en, DEC_wrt_en, IF_flush, DEC_flush, pc_redirect, mem_err
  );

endinterface

// File: rtl/pipe_hazard_ctrl_hazard_detect.sv
// Combinational load-use and branch-mispredict detection for the hazard
// controller; no state.
module hazard_detect
  import pipe_hazard_ctrl_pkg::*;
#(
  parameter int unsigned REG_INDEX_BIT_WIDTH = RegIdxWidth
) (
  input  logic [REG_INDEX_BIT_WIDTH-1:0] rs1,
  input  logic [REG_INDEX_BIT_WIDTH-1:0] rs2,
  input  logic                           use_rs1,
  input  logic                           use_rs2,
  input  logic [REG_INDEX_BIT_WIDTH-1:0] dec_rd,
  input  logic                           dec_wr_reg,
  input  logic                           dec_me_mux_sel,
  input  logic                           dec_prediction,
  input  logic                           ex_br_valid,
  input  logic                           ex_br_taken,
  output logic                           load_use,
  output logic                           mispredict
);

  logic rd_live;
  logic rs1_hit;
  logic rs2_hit;

  // Writes to the zero register are discarded, so they never create a dependency.
  assign rd_live = dec_wr_reg && dec_me_mux_sel &&
                   (dec_rd != REG_INDEX_BIT_WIDTH'(RegZero));
  assign rs1_hit = use_rs1 && (rs1 == dec_rd);
  assign rs2_hit = use_rs2 && (rs2 == dec_rd);

  assign load_use   = rd_live && (rs1_hit || rs2_hit);
  assign mispredict = ex_br_valid && (ex_br_taken != dec_prediction);

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Front-end hazard controller: stall/bubble/freeze/mispredict-flush decode plus
// memory-timeout FSM. Define HAZARD_STATS_EN to add saturating event counters.
module pipe_hazard_ctrl
  import pipe_hazard_ctrl_pkg::*;
#(
  parameter int unsigned DBITS               = 32,
  parameter int unsigned REG_INDEX_BIT_WIDTH = RegIdxWidth,
  parameter int unsigned MEM_TIMEOUT         = 64
) (
  input  logic                   clk,
  input  logic                   reset,
  pipe_hazard_ctrl_if.slave      hz
`ifdef HAZARD_STATS_EN
  ,
  output logic [DBITS-1:0]       stall_cnt,
  output logic [DBITS-1:0]       flush_cnt,
  output logic [DBITS-1:0]       freeze_cnt
`endif
);

  localparam int unsigned    CntW       = $clog2(MEM_TIMEOUT + 1);
  localparam logic [CntW-1:0] CntOne     = CntW'(1);
  localparam logic [CntW-1:0] TimeoutVal = CntW'(MEM_TIMEOUT);

  hz_state_e       state_q, state_d;
  logic [CntW-1:0] wait_q, wait_d, wait_inc;
  logic            mem_err_q, mem_err_d;

  logic mem_stall;
  logic mispredict;
  logic load_use;

  assign mem_stall = hz.mem_req && !hz.mem_ready;

  hazard_detect #(
    .REG_INDEX_BIT_WIDTH (REG_INDEX_BIT_WIDTH)
  ) u_hazard_detect (
    .rs1            (hz.rs1),
    .rs2            (hz.rs2),
    .use_rs1        (hz.use_rs1),
    .use_rs2        (hz.use_rs2),
    .dec_rd         (hz.DEC_rd),
    .dec_wr_reg     (hz.DEC_wrReg),
    .dec_me_mux_sel (hz.DEC_ME_mux_sel),
    .dec_prediction (hz.DEC_prediction),
    .ex_br_valid    (hz.ex_br_valid),
    .ex_br_taken    (hz.ex_br_taken),
    .load_use       (load_use),
    .mispredict     (mispredict)
  );

  assign wait_inc = (wait_q == {CntW{1'b1}}) ? wait_q : wait_q + CntOne;

  always_comb begin
    state_d   = state_q;
    wait_d    = wait_q;
    mem_err_d = mem_err_q;
    unique case (state_q)
      StRun: begin
        if (mem_stall) begin
          wait_d = CntOne;
          if (CntOne >= TimeoutVal) begin
            state_d   = StErr;
            mem_err_d = 1'b1;
          end else begin
            state_d = StFreeze;
          end
        end
      end
      StFreeze: begin
        if (mem_stall) begin
          wait_d = wait_inc;
          if (wait_inc >= TimeoutVal) begin
            state_d   = StErr;
            mem_err_d = 1'b1;
          end
        end else begin
          state_d = StRun;
          wait_d  = '0;
        end
      end
      StErr: begin
        state_d = StErr;
      end
      default: begin
        state_d = StRun;
        wait_d  = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q   <= StRun;
      wait_q    <= '0;
      mem_err_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      wait_q    <= wait_d;
      mem_err_q <= mem_err_d;
    end
  end

  logic pc_wrt_en, if_wrt_en, dec_wrt_en, if_flush, dec_flush, pc_redirect;
  logic active;

  // Release from FREEZE falls through to the RUN decode in the same cycle.
  assign active = reset && (state_q != StErr);

  always_comb begin
    pc_wrt_en   = 1'b1;
    if_wrt_en   = 1'b1;
    dec_wrt_en  = 1'b1;
    if_flush    = 1'b0;
    dec_flush   = 1'b0;
    pc_redirect = 1'b0;
    if (!active) begin
      pc_wrt_en  = 1'b0;
      if_wrt_en  = 1'b0;
      dec_wrt_en = 1'b0;
      if_flush   = 1'b1;
      dec_flush  = 1'b1;
    end else if (mem_stall) begin
      pc_wrt_en  = 1'b0;
      if_wrt_en  = 1'b0;
      dec_wrt_en = 1'b0;
    end else if (mispredict) begin
      pc_redirect = 1'b1;
      if_flush    = 1'b1;
      dec_flush   = 1'b1;
    end else if (load_use) begin
      pc_wrt_en = 1'b0;
      if_wrt_en = 1'b0;
      dec_flush = 1'b1;
    end
  end

  assign hz.pc_wrt_en   = pc_wrt_en;
  assign hz.IF_wrt_en   = if_wrt_en;
  assign hz.DEC_wrt_en  = dec_wrt_en;
  assign hz.IF_flush    = if_flush;
  assign hz.DEC_flush   = dec_flush;
  assign hz.pc_redirect = pc_redirect;
  assign hz.mem_err     = mem_err_q;

`ifdef HAZARD_STATS_EN
  logic [DBITS-1:0] stall_cnt_q, flush_cnt_q, freeze_cnt_q;
  logic             stall_ev, flush_ev, freeze_ev;

  assign freeze_ev = active && mem_stall;
  assign flush_ev  = active && !mem_stall && mispredict;
  assign stall_ev  = active && !mem_stall && !mispredict && load_use;

  always_ff @(posedge clk) begin
    if (!reset) begin
      stall_cnt_q  <= '0;
      flush_cnt_q  <= '0;
      freeze_cnt_q <= '0;
    end else begin
      if (stall_ev && (stall_cnt_q != {DBITS{1'b1}}))   stall_cnt_q  <= stall_cnt_q + 1'b1;
      if (flush_ev && (flush_cnt_q != {DBITS{1'b1}}))   flush_cnt_q  <= flush_cnt_q + 1'b1;
      if (freeze_ev && (freeze_cnt_q != {DBITS{1'b1}})) freeze_cnt_q <= freeze_cnt_q + 1'b1;
    end
  end

  assign stall_cnt  = stall_cnt_q;
  assign flush_cnt  = flush_cnt_q;
  assign freeze_cnt = freeze_cnt_q;
`endif

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed bench for pipe_hazard_ctrl: one instance at the default timeout and
// one with MEM_TIMEOUT = 4, expectations queued per step and checked at negedge.
module tb_pipe_hazard_ctrl;

  logic clk = 1'b0;
  logic reset;

  always #5 clk = ~clk;

  pipe_hazard_ctrl_if ifa ();
  pipe_hazard_ctrl_if ifb ();

  pipe_hazard_ctrl #(
    .MEM_TIMEOUT (64)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .hz    (ifa)
  );

  pipe_hazard_ctrl #(
    .MEM_TIMEOUT (4)
  ) dut_t (
    .clk   (clk),
    .reset (reset),
    .hz    (ifb)
  );

  // Output vector: {pc_wrt_en, IF_wrt_en, DEC_wrt_en, IF_flush, DEC_flush, pc_redirect, mem_err}
  localparam logic [6:0] ONorm   = 7'b111_00_0_0;
  localparam logic [6:0] OLdUse  = 7'b001_01_0_0;
  localparam logic [6:0] OMisp   = 7'b111_11_1_0;
  localparam logic [6:0] OFrz    = 7'b000_00_0_0;
  localparam logic [6:0] OErr    = 7'b000_11_0_1;
  localparam logic [6:0] ORst    = 7'b000_11_0_0;

  int n_cmp  = 0;
  int n_fail = 0;

  string      tag_q[$];
  logic [7:0] exp_q[$];

  function automatic logic [6:0] outs(input bit sel);
    if (sel)
      return {ifb.pc_wrt_en, ifb.IF_wrt_en, ifb.DEC_wrt_en, ifb.IF_flush,
              ifb.DEC_flush, ifb.pc_redirect, ifb.mem_err};
    return {ifa.pc_wrt_en, ifa.IF_wrt_en, ifa.DEC_wrt_en, ifa.IF_flush,
            ifa.DEC_flush, ifa.pc_redirect, ifa.mem_err};
  endfunction

  task automatic idle_all();
    ifa.rs1 = '0; ifa.rs2 = '0; ifa.use_rs1 = 1'b0; ifa.use_rs2 = 1'b0;
    ifa.DEC_rd = '0; ifa.DEC_wrReg = 1'b0; ifa.DEC_ME_mux_sel = 1'b0;
    ifa.DEC_prediction = 1'b0; ifa.ex_br_valid = 1'b0; ifa.ex_br_taken = 1'b0;
    ifa.mem_req = 1'b0; ifa.mem_ready = 1'b0;
    ifb.rs1 = '0; ifb.rs2 = '0; ifb.use_rs1 = 1'b0; ifb.use_rs2 = 1'b0;
    ifb.DEC_rd = '0; ifb.DEC_wrReg = 1'b0; ifb.DEC_ME_mux_sel = 1'b0;
    ifb.DEC_prediction = 1'b0; ifb.ex_br_valid = 1'b0; ifb.ex_br_taken = 1'b0;
    ifb.mem_req = 1'b0; ifb.mem_ready = 1'b0;
  endtask

  task automatic set_lu_a(input logic [3:0] rd, input logic [3:0] s1, input logic u1,
                          input logic [3:0] s2, input logic u2, input logic ld);
    ifa.DEC_rd = rd; ifa.rs1 = s1; ifa.use_rs1 = u1; ifa.rs2 = s2; ifa.use_rs2 = u2;
    ifa.DEC_wrReg = 1'b1; ifa.DEC_ME_mux_sel = ld;
  endtask

  task automatic set_br_a(input logic v, input logic taken, input logic pred);
    ifa.ex_br_valid = v; ifa.ex_br_taken = taken; ifa.DEC_prediction = pred;
  endtask

  task automatic expect_out(input string tag, input bit sel, input logic [6:0] e);
    tag_q.push_back(tag);
    exp_q.push_back({sel, e});
  endtask

  // Checks every queued expectation at negedge, then advances past the next posedge.
  task automatic step();
    string      t;
    logic [7:0] e;
    logic [6:0] o;
    @(negedge clk);
    while (exp_q.size() > 0) begin
      t = tag_q.pop_front();
      e = exp_q.pop_front();
      o = outs(e[7]);
      n_cmp++;
      assert (o === e[6:0])
      else begin
        n_fail++;
        $error("FAIL %s: observed %b expected %b", t, o, e[6:0]);
      end
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    idle_all();
    reset = 1'b0;
    repeat (2) @(posedge clk);
    #1;

    // Reset state
    expect_out("reset_a", 1'b0, ORst);
    expect_out("reset_b", 1'b1, ORst);
    step();

    reset = 1'b1;
    expect_out("run_idle_a", 1'b0, ONorm);
    expect_out("run_idle_b", 1'b1, ONorm);
    step();

    // Load-use on rs1, then the bubble occupies EX
    set_lu_a(4'd3, 4'd3, 1'b1, 4'd0, 1'b0, 1'b1);
    expect_out("lu_rs1", 1'b0, OLdUse);
    step();
    ifa.DEC_wrReg = 1'b0; ifa.DEC_ME_mux_sel = 1'b0;
    expect_out("lu_bubble", 1'b0, ONorm);
    step();

    set_lu_a(4'd5, 4'd2, 1'b1, 4'd5, 1'b1, 1'b1);
    expect_out("lu_rs2", 1'b0, OLdUse);
    step();
    set_lu_a(4'd3, 4'd3, 1'b0, 4'd1, 1'b1, 1'b1);
    expect_out("lu_unused_src", 1'b0, ONorm);
    step();
    set_lu_a(4'd3, 4'd3, 1'b1, 4'd0, 1'b0, 1'b0);
    expect_out("lu_alu_op", 1'b0, ONorm);
    step();
    set_lu_a(4'd0, 4'd0, 1'b1, 4'd0, 1'b1, 1'b1);
    expect_out("lu_rd_zero", 1'b0, ONorm);
    step();

    // Mispredict beats a concurrent load-use
    set_lu_a(4'd3, 4'd3, 1'b1, 4'd0, 1'b0, 1'b1);
    set_br_a(1'b1, 1'b0, 1'b1);
    expect_out("misp_over_lu", 1'b0, OMisp);
    step();
    idle_all();
    set_br_a(1'b1, 1'b1, 1'b1);
    expect_out("br_correct", 1'b0, ONorm);
    step();
    set_br_a(1'b1, 1'b1, 1'b0);
    expect_out("misp_nt_pred", 1'b0, OMisp);
    step();
    set_br_a(1'b0, 1'b1, 1'b0);
    expect_out("br_not_valid", 1'b0, ONorm);
    step();

    // Freeze for 5 cycles with a held mispredict, then release honours it
    set_br_a(1'b1, 1'b0, 1'b1);
    ifa.mem_req = 1'b1; ifa.mem_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      expect_out("freeze", 1'b0, OFrz);
      step();
    end
    ifa.mem_ready = 1'b1;
    expect_out("freeze_release_misp", 1'b0, OMisp);
    step();
    idle_all();
    expect_out("after_release", 1'b0, ONorm);
    step();

    // Release by mem_req dropping, with a load-use present
    ifa.mem_req = 1'b1;
    repeat (2) begin
      expect_out("freeze2", 1'b0, OFrz);
      step();
    end
    ifa.mem_req = 1'b0;
    set_lu_a(4'd7, 4'd7, 1'b1, 4'd0, 1'b0, 1'b1);
    expect_out("release_req_drop_lu", 1'b0, OLdUse);
    step();
    idle_all();

    // Reset on freeze cycle 2 of the short-timeout instance
    ifb.mem_req = 1'b1;
    expect_out("b_freeze1", 1'b1, OFrz);
    step();
    reset = 1'b0;
    expect_out("b_reset_mid_freeze", 1'b1, ORst);
    step();
    ifb.mem_req = 1'b0;
    expect_out("b_reset_hold", 1'b1, ORst);
    step();
    reset = 1'b1;
    expect_out("b_after_reset", 1'b1, ONorm);
    step();

    // Counter restarted: 3 stalled cycles stay below the timeout of 4
    ifb.mem_req = 1'b1;
    for (int i = 0; i < 3; i++) begin
      expect_out("b_freeze_short", 1'b1, OFrz);
      step();
    end
    ifb.mem_ready = 1'b1;
    expect_out("b_release_no_err", 1'b1, ONorm);
    step();
    ifb.mem_req = 1'b0; ifb.mem_ready = 1'b0;
    expect_out("b_idle", 1'b1, ONorm);
    step();

    // Timeout: 4 stalled cycles then sticky ERR
    ifb.mem_req = 1'b1;
    for (int i = 0; i < 4; i++) begin
      expect_out("b_freeze_to", 1'b1, OFrz);
      step();
    end
    expect_out("b_timeout_err", 1'b1, OErr);
    step();
    ifb.mem_ready = 1'b1;
    expect_out("b_err_ready", 1'b1, OErr);
    step();
    ifb.mem_req = 1'b0; ifb.mem_ready = 1'b0;
    expect_out("b_err_sticky", 1'b1, OErr);
    expect_out("a_unaffected", 1'b0, ONorm);
    step();
    reset = 1'b0;
    expect_out("b_err_reset_forced", 1'b1, OErr);
    step();
    expect_out("b_err_cleared", 1'b1, ORst);
    step();
    reset = 1'b1;
    expect_out("b_run_after_err", 1'b1, ONorm);
    step();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
